// File: rtl/mem1p_arb2_pkg.sv
// Shared types and constants for the two-requester single-port RAM arbiter.
// MEM1P_ARB_RDATA_REG_EN selects a registered read-data path (read latency 2).
package mem1p_arb2_pkg;

    typedef logic [0:0] req_idx_t;

    localparam int unsigned NREQ = 2;

`ifdef MEM1P_ARB_RDATA_REG_EN
    localparam int unsigned RD_LAT = 2;
`else
    localparam int unsigned RD_LAT = 1;
`endif

    // Address width for a given depth; a one-word RAM still gets one address bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem1p_arb2_if.sv
// Bundle of requester-side and RAM-side signals for mem1p_arb2.
interface mem1p_arb2_if #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned WIDTH = 24
) ();
    import mem1p_arb2_pkg::*;

    localparam int unsigned A = addr_width(DEPTH);

    logic             req0;
    logic             req1;
    logic             lock0;
    logic             lock1;
    logic             wnr0;
    logic             wnr1;
    logic [A-1:0]     addr0;
    logic [A-1:0]     addr1;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic             gnt0;
    logic             gnt1;
    logic             rvalid0;
    logic             rvalid1;
    logic [WIDTH-1:0] rdata;
    logic             m_me;
    logic             m_wnr;
    logic [A-1:0]     m_addr;
    logic [WIDTH-1:0] m_din;
    logic [WIDTH-1:0] m_dout;

    modport slave (
        input  req0, req1, lock0, lock1, wnr0, wnr1, addr0, addr1, din0, din1, m_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, m_me, m_wnr, m_addr, m_din
    );

    modport master (
        output req0, req1, lock0, lock1, wnr0, wnr1, addr0, addr1, din0, din1, m_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, m_me, m_wnr, m_addr, m_din
    );

endinterface

// File: rtl/mem1p_arb2_rr_arb2_lock.sv
// Two-way round-robin arbiter with grant locking; grant is combinational,
// gated by an 'armed' flop so nothing is granted in the first cycle after reset.
module rr_arb2_lock
    import mem1p_arb2_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt_c
);

    logic     armed;
    logic     owner_vld;
    req_idx_t owner;
    req_idx_t ptr;
    req_idx_t sel_c;
    logic     lock_held_c;
    logic     any_c;

    // Winner selection: held lock first, then lone requester, then pointer.
    always_comb begin
        lock_held_c = owner_vld & req[owner] & lock[owner];
        sel_c       = ptr;
        if (lock_held_c) begin
            sel_c = owner;
        end else if (req == 2'b01) begin
            sel_c = 1'b0;
        end else if (req == 2'b10) begin
            sel_c = 1'b1;
        end
        any_c        = armed & (|req);
        gnt_c        = '0;
        if (any_c) begin
            gnt_c[sel_c] = 1'b1;
        end
    end

    // Pointer always moves away from the winner, so a released lock hands over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            ptr       <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (any_c) begin
                ptr       <= ~sel_c;
                owner     <= sel_c;
                owner_vld <= lock[sel_c];
            end else begin
                owner_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem1p_arb2.sv
// Two-requester arbiter/sequencer for one single-port synchronous RAM.
// Define MEM1P_ARB_RDATA_REG_EN to register rdata (read latency 2 instead of 1).
module mem1p_arb2
    import mem1p_arb2_pkg::*;
#(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned WIDTH = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    mem1p_arb2_if.slave  bus
);

    localparam int unsigned A = addr_width(DEPTH);

    logic [1:0]       gnt_c;
    logic [1:0]       rd_tag_c;
    logic [A-1:0]     addr_sel_c;
    logic [WIDTH-1:0] din_sel_c;
    logic [1:0]       rv1_q;

    rr_arb2_lock u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({bus.req1,  bus.req0}),
        .lock  ({bus.lock1, bus.lock0}),
        .gnt_c (gnt_c)
    );

    assign bus.gnt0 = gnt_c[0];
    assign bus.gnt1 = gnt_c[1];

    // RAM drive follows requester 1 only when it wins; idle shows requester 0.
    assign addr_sel_c  = gnt_c[1] ? bus.addr1 : bus.addr0;
    assign din_sel_c   = gnt_c[1] ? bus.din1  : bus.din0;
    assign bus.m_me    = |gnt_c;
    assign bus.m_wnr   = gnt_c[1] ? bus.wnr1  : bus.wnr0;
    assign bus.m_addr  = addr_sel_c;
    assign bus.m_din   = din_sel_c;

    assign rd_tag_c = gnt_c & ~{bus.wnr1, bus.wnr0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv1_q <= '0;
        end else begin
            rv1_q <= rd_tag_c;
        end
    end

`ifdef MEM1P_ARB_RDATA_REG_EN
    logic [1:0]       rv2_q;
    logic [WIDTH-1:0] rdata_q;

    // Capture RAM output only on the cycle it carries a read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv2_q   <= '0;
            rdata_q <= '0;
        end else begin
            rv2_q <= rv1_q;
            if (|rv1_q) begin
                rdata_q <= bus.m_dout;
            end
        end
    end

    assign bus.rvalid0 = rv2_q[0];
    assign bus.rvalid1 = rv2_q[1];
    assign bus.rdata   = rdata_q;
`else
    assign bus.rvalid0 = rv1_q[0];
    assign bus.rvalid1 = rv1_q[1];
    assign bus.rdata   = bus.m_dout;
`endif

endmodule

// File: tb/tb_mem1p_arb2.sv
// Scoreboard bench for mem1p_arb2: rule-level arbiter model plus shadow memory,
// read returns queued at issue and checked by an independent monitor.
module tb_mem1p_arb2;
    import mem1p_arb2_pkg::*;

    localparam int unsigned DEPTH = 2048;
    localparam int unsigned WIDTH = 24;
    localparam int unsigned A     = addr_width(DEPTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem1p_arb2_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    mem1p_arb2 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural single-port RAM: registered dout, held when not reading.
    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] ram_dout = '0;

    always @(posedge clk) begin
        if (bus.m_me) begin
            if (bus.m_wnr) ram[bus.m_addr] <= bus.m_din;
            else           ram_dout        <= ram[bus.m_addr];
        end
    end
    assign bus.m_dout = ram_dout;

    typedef struct {
        int unsigned      due;
        int               who;
        logic [WIDTH-1:0] data;
    } rd_exp_t;

    rd_exp_t exp_q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc   = 0;

    logic [WIDTH-1:0] shadow [DEPTH];
    int  ptr_m     = 0;
    int  own_m     = 0;
    bit  own_vld_m = 1'b0;
    bit  armed_m   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference arbiter: who should own the RAM this cycle, and what it does.
    always @(negedge clk) begin
        bit [1:0]         req;
        bit [1:0]         lk;
        int               win;
        bit [1:0]         exp_g;
        logic [A-1:0]     a;
        logic [WIDTH-1:0] d;
        logic             w;
        rd_exp_t          e;

        req = {bus.req1, bus.req0};
        lk  = {bus.lock1, bus.lock0};
        if (!rst_n) begin
            armed_m   = 1'b0;
            ptr_m     = 0;
            own_vld_m = 1'b0;
        end
        win = -1;
        if (armed_m && req != 2'b00) begin
            if (own_vld_m && req[own_m] && lk[own_m]) win = own_m;
            else if (req == 2'b11)                   win = ptr_m;
            else if (req[0])                         win = 0;
            else                                     win = 1;
        end
        exp_g = (win < 0) ? 2'b00 : ((win == 1) ? 2'b10 : 2'b01);
        a = (win == 1) ? bus.addr1 : bus.addr0;
        d = (win == 1) ? bus.din1  : bus.din0;
        w = (win == 1) ? bus.wnr1  : bus.wnr0;

        chk("gnt",    32'({bus.gnt1, bus.gnt0}), 32'(exp_g));
        chk("m_me",   32'(bus.m_me),  32'(exp_g != 2'b00));
        chk("m_addr", 32'(bus.m_addr), 32'(a));
        chk("m_wnr",  32'(bus.m_wnr),  32'(w));
        chk("m_din",  32'(bus.m_din),  32'(d));

        if (win >= 0) begin
            if (w) begin
                shadow[a] = d;
            end else begin
                e.due  = cyc + RD_LAT;
                e.who  = win;
                e.data = shadow[a];
                exp_q.push_back(e);
            end
            ptr_m     = 1 - win;
            own_m     = win;
            own_vld_m = lk[win];
        end else begin
            own_vld_m = 1'b0;
        end
        armed_m = rst_n;
    end

    // Read-return monitor, decoupled from stimulus and from the grant model.
    always @(negedge clk) begin
        bit [1:0] exp_rv;
        bit [1:0] act_rv;
        rd_exp_t  e;
        exp_rv = 2'b00;
        act_rv = {bus.rvalid1, bus.rvalid0};
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            chk("lost_read", 32'(cyc), 32'(e.due));
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e      = exp_q.pop_front();
            exp_rv = (e.who == 1) ? 2'b10 : 2'b01;
        end
        chk("rvalid", 32'(act_rv), 32'(exp_rv));
        if (exp_rv != 2'b00 && act_rv == exp_rv)
            chk("rdata", 32'(bus.rdata), 32'(e.data));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set0(input bit r, input bit l, input bit w,
                        input int unsigned a, input int unsigned d);
        bus.req0  = r;
        bus.lock0 = l;
        bus.wnr0  = w;
        bus.addr0 = A'(a);
        bus.din0  = WIDTH'(d);
    endtask

    task automatic set1(input bit r, input bit l, input bit w,
                        input int unsigned a, input int unsigned d);
        bus.req1  = r;
        bus.lock1 = l;
        bus.wnr1  = w;
        bus.addr1 = A'(a);
        bus.din1  = WIDTH'(d);
    endtask

    task automatic idle(input int n);
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick(n);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i]    = '0;
            shadow[i] = '0;
        end
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick(2);

        // Both requesting across reset release: nothing, then 0,1,0,1...
        set0(1, 0, 0, 0, 0);
        set1(1, 0, 0, 1, 0);
        tick(1);
        rst_n = 1'b1;
        tick(6);
        idle(2);

        // Write then immediately read the same address.
        set0(1, 0, 1, 5, 24'hABCDEF);
        tick(1);
        set0(1, 0, 0, 5, 0);
        tick(1);
        idle(3);

        // Preload, then both requesters read continuously.
        set0(1, 0, 1, 3, 24'h11);
        tick(1);
        set0(1, 0, 1, 4, 24'h22);
        tick(1);
        set0(1, 0, 0, 3, 0);
        set1(1, 0, 0, 4, 0);
        tick(8);
        idle(3);

        // Lock held by 0 for four cycles against a competing requester 1.
        set1(1, 0, 0, 4, 0);
        tick(1);
        set0(1, 1, 1, 10, 24'h100);
        set1(1, 0, 0, 3, 0);
        for (int i = 0; i < 4; i++) begin
            bus.din0 = WIDTH'(24'h100 + i);
            tick(1);
        end
        set0(1, 0, 0, 10, 0);
        tick(3);
        idle(2);

        // Reset pulse right after a locked read grant to requester 1.
        set1(1, 1, 0, 4, 0);
        tick(1);
        rst_n = 1'b0;
        exp_q.delete();
        set0(1, 0, 0, 3, 0);
        tick(1);
        rst_n = 1'b1;
        tick(5);
        idle(2);

        // Requester 1 alone for eight cycles, then both.
        for (int i = 0; i < 8; i++) begin
            set1(1, 0, i % 2, 20 + i / 2, 24'h300 + i);
            tick(1);
        end
        set0(1, 0, 0, 20, 0);
        set1(1, 0, 0, 21, 0);
        tick(6);
        idle(2);

        // Randomized traffic on a small address window.
        for (int i = 0; i < 600; i++) begin
            set0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
            set1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
            tick(1);
        end
        idle(5);

        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
